// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared fixed-point ALU.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface alu_arbiter_if #(
  parameter int INST_W = 4,
  parameter int DATA_W = 16
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic        [INST_W-1:0] req0_inst;
  logic signed [DATA_W-1:0] req0_a;
  logic signed [DATA_W-1:0] req0_b;
  logic                     rsp0_valid;
  logic signed [DATA_W-1:0] rsp0_data;
  logic                     rsp0_err;

  logic                     req1_valid;
  logic                     req1_ready;
  logic        [INST_W-1:0] req1_inst;
  logic signed [DATA_W-1:0] req1_a;
  logic signed [DATA_W-1:0] req1_b;
  logic                     rsp1_valid;
  logic signed [DATA_W-1:0] rsp1_data;
  logic                     rsp1_err;

  logic                     alu_in_valid;
  logic                     alu_busy;
  logic        [INST_W-1:0] alu_inst;
  logic signed [DATA_W-1:0] alu_data_a;
  logic signed [DATA_W-1:0] alu_data_b;
  logic                     alu_out_valid;
  logic signed [DATA_W-1:0] alu_data;

  modport slave (
    input  req0_valid, req0_inst, req0_a, req0_b,
    input  req1_valid, req1_inst, req1_a, req1_b,
    input  alu_busy, alu_out_valid, alu_data,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output alu_in_valid, alu_inst, alu_data_a, alu_data_b
  );

  modport master (
    output req0_valid, req0_inst, req0_a, req0_b,
    output req1_valid, req1_inst, req1_a, req1_b,
    output alu_busy, alu_out_valid, alu_data,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  alu_in_valid, alu_inst, alu_data_a, alu_data_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. One operation is
// outstanding at a time; its result (or a watchdog error) returns to its issuer.
module alu_arbiter #(
  parameter int INST_W  = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  alu_arbiter_if.slave  bus
);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t                   state;
  state_t                   state_nx;
  logic                     last_gnt;
  logic                     gnt;
  logic                     gnt_any;
  logic                     accept;
  logic                     owner;
  logic                     tmr_hit;
  logic        [TMR_W-1:0]  timer;
  logic        [INST_W-1:0] inst_q;
  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] b_q;
  logic signed [DATA_W-1:0] rsp_data;
  logic                     rsp_err;

  // Pick the requester; on a tie the one that did not win last time goes first
  always_comb begin
    gnt_any = bus.req0_valid | bus.req1_valid;
    gnt     = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) gnt = ~last_gnt;
  end

  assign accept  = (state == IDLE) && gnt_any && !bus.alu_busy;
  assign tmr_hit = (timer == TMR_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: a result arriving on the last watchdog cycle still wins over the error
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (bus.alu_out_valid || tmr_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: ready is masked by reset so every output reads 0 while reset is held
  always_comb begin
    bus.req0_ready   = i_rst_n & accept & ~gnt;
    bus.req1_ready   = i_rst_n & accept & gnt;
    bus.alu_in_valid = (state == ISSUE);
    bus.alu_inst     = inst_q;
    bus.alu_data_a   = a_q;
    bus.alu_data_b   = b_q;
    bus.rsp0_valid   = 1'b0;
    bus.rsp0_data    = '0;
    bus.rsp0_err     = 1'b0;
    bus.rsp1_valid   = 1'b0;
    bus.rsp1_data    = '0;
    bus.rsp1_err     = 1'b0;
    if (state == RESP) begin
      if (owner) begin
        bus.rsp1_valid = 1'b1;
        bus.rsp1_data  = rsp_data;
        bus.rsp1_err   = rsp_err;
      end else begin
        bus.rsp0_valid = 1'b1;
        bus.rsp0_data  = rsp_data;
        bus.rsp0_err   = rsp_err;
      end
    end
  end

  // Capture the accepted command and its owner; advance the round-robin pointer on response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner    <= 1'b0;
      inst_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      last_gnt <= 1'b1;
    end else begin
      if (accept) begin
        owner  <= gnt;
        inst_q <= gnt ? bus.req1_inst : bus.req0_inst;
        a_q    <= gnt ? bus.req1_a    : bus.req0_a;
        b_q    <= gnt ? bus.req1_b    : bus.req0_b;
      end
      if (state == RESP) last_gnt <= owner;
    end
  end

  // Watchdog timer and response capture; the timer stops when leaving WAIT so it never wraps
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ISSUE: timer <= '0;
        WAIT: begin
          if (bus.alu_out_valid) begin
            rsp_data <= bus.alu_data;
            rsp_err  <= 1'b0;
          end else if (tmr_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: drives both requesters and plays the ALU, comparing
// against a transaction-level model of round-robin order, latency and watchdog.
module tb_alu_arbiter;
  localparam int INST_W  = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.INST_W(INST_W), .DATA_W(DATA_W)) bus ();

  alu_arbiter #(.INST_W(INST_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int m_last = 1;   // model of the requester that won most recently

  // Observations of one transaction
  int          o_acc, start_cyc, acc_cyc, iv_cyc, iv_cnt, rsp_port, rsp_cyc, rsp_cnt;
  bit          cross_bad, busy_ready_bad;
  logic [35:0] s_op;
  logic [15:0] s_data;
  logic        s_err;

  task automatic zero_inputs();
    bus.req0_valid = 0; bus.req0_inst = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_inst = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.alu_busy = 0; bus.alu_out_valid = 0; bus.alu_data = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = 1;
  endtask

  // Drives one command (with optional busy cycles), plays the ALU with latency lat
  // (lat<=0: never answers) and optionally a stray result stray cycles after the response.
  task automatic run_txn(input bit v0, input bit v1, input logic [35:0] op0, input logic [35:0] op1,
                         input int lat, input logic [15:0] rdata, input int busy_n, input int stray);
    int limit;
    o_acc = -1; iv_cyc = -1; iv_cnt = 0; rsp_port = -1; rsp_cyc = -1; rsp_cnt = 0;
    cross_bad = 0; busy_ready_bad = 0; s_op = '0; s_data = '0; s_err = 0;
    @(posedge clk); #1;
    bus.req0_valid = v0; {bus.req0_inst, bus.req0_a, bus.req0_b} = op0;
    bus.req1_valid = v1; {bus.req1_inst, bus.req1_a, bus.req1_b} = op1;
    for (int k = 0; k < busy_n + 8 && o_acc < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      bus.alu_busy = (k < busy_n);
      @(negedge clk);
      if (k == 0) start_cyc = cyc;
      if (bus.alu_busy && (bus.req0_ready || bus.req1_ready)) busy_ready_bad = 1;
      if (bus.req0_ready && bus.req1_ready) cross_bad = 1;
      if (bus.req0_ready) begin o_acc = 0; acc_cyc = cyc; end
      else if (bus.req1_ready) begin o_acc = 1; acc_cyc = cyc; end
    end
    if (o_acc < 0) begin
      zero_inputs();
      return;
    end
    limit = TIMEOUT + ((lat > 0) ? lat : 0) + ((stray > 0) ? stray : 0) + 12;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin bus.req0_valid = 0; bus.req1_valid = 0; bus.alu_busy = 0; end
      bus.alu_out_valid = (iv_cyc >= 0 && lat > 0 && cyc == iv_cyc + lat) ||
                          (rsp_cyc >= 0 && stray > 0 && cyc == rsp_cyc + stray);
      bus.alu_data = bus.alu_out_valid ? rdata : 16'h0;
      @(negedge clk);
      if (bus.alu_in_valid) begin
        iv_cnt++;
        if (iv_cyc < 0) begin
          iv_cyc = cyc;
          s_op = {bus.alu_inst, bus.alu_data_a, bus.alu_data_b};
        end
      end
      if (bus.rsp0_valid && bus.rsp1_valid) cross_bad = 1;
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin
          rsp_cyc = cyc;
          if (bus.rsp0_valid) begin
            rsp_port = 0; s_data = bus.rsp0_data; s_err = bus.rsp0_err;
            if (bus.rsp1_data !== 16'h0 || bus.rsp1_err !== 1'b0) cross_bad = 1;
          end else begin
            rsp_port = 1; s_data = bus.rsp1_data; s_err = bus.rsp1_err;
            if (bus.rsp0_data !== 16'h0 || bus.rsp0_err !== 1'b0) cross_bad = 1;
          end
        end
      end
      if (rsp_cyc >= 0 && cyc >= rsp_cyc + ((stray > 0) ? stray + 2 : 1)) break;
    end
    bus.alu_out_valid = 0;
    bus.alu_data = '0;
  endtask

  task automatic test_reset();
    zero_inputs();
    rst_n = 1'b0;
    bus.req0_valid = 1; bus.req1_valid = 1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready, bus.alu_in_valid, bus.alu_inst, bus.alu_data_a, bus.alu_data_b,
         bus.rsp0_valid, bus.rsp0_data, bus.rsp0_err, bus.rsp1_valid, bus.rsp1_data, bus.rsp1_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got r0=%b r1=%b iv=%b inst=%h a=%h b=%h v0=%b v1=%b required all 0",
               bus.req0_ready, bus.req1_ready, bus.alu_in_valid, bus.alu_inst, bus.alu_data_a,
               bus.alu_data_b, bus.rsp0_valid, bus.rsp1_valid);
    end
    zero_inputs();
    rst_n = 1'b1;
    m_last = 1;
    @(negedge clk);
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready, bus.alu_in_valid, bus.rsp0_valid, bus.rsp1_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b required 00000",
               {bus.req0_ready, bus.req1_ready, bus.alu_in_valid, bus.rsp0_valid, bus.rsp1_valid});
    end
  endtask

  task automatic test_basic();
    run_txn(1, 0, {4'b0000, 16'h0400, 16'h0800}, 36'h0, 1, 16'h0C00, 0, -1);
    n_chk++;
    if (o_acc !== 0) begin n_fail++; $display("FAIL basic_grant: got %0d required 0", o_acc); end
    n_chk++;
    if (iv_cyc !== acc_cyc + 1 || iv_cnt !== 1) begin
      n_fail++; $display("FAIL basic_issue: in_valid at T+%0d count %0d, required T+1 count 1", iv_cyc - acc_cyc, iv_cnt);
    end
    n_chk++;
    if (s_op !== {4'b0000, 16'h0400, 16'h0800}) begin
      n_fail++; $display("FAIL basic_operands: got %h required %h", s_op, {4'b0000, 16'h0400, 16'h0800});
    end
    n_chk++;
    if (rsp_port !== 0 || rsp_cyc !== acc_cyc + 3 || s_data !== 16'h0C00 || s_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_response: port %0d at T+%0d data %h err %b, required port 0 at T+3 data 0c00 err 0",
                         rsp_port, rsp_cyc - acc_cyc, s_data, s_err);
    end
    n_chk++;
    if (cross_bad !== 0 || rsp_cnt !== 1) begin
      n_fail++; $display("FAIL basic_other_port: cross=%0d responses=%0d required 0 and 1", cross_bad, rsp_cnt);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.alu_inst, bus.alu_data_a, bus.alu_data_b} !== {4'b0000, 16'h0400, 16'h0800}) begin
      n_fail++; $display("FAIL basic_operand_hold: got %h required %h",
                         {bus.alu_inst, bus.alu_data_a, bus.alu_data_b}, {4'b0000, 16'h0400, 16'h0800});
    end
    m_last = 0;
  endtask

  task automatic test_round_robin();
    logic [35:0] op0, op1;
    logic [15:0] rd;
    int exp_w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      op0 = {$urandom, $urandom}; op1 = {$urandom, $urandom}; rd = 16'($urandom);
      exp_w = 1 - m_last;
      run_txn(1, 1, op0, op1, $urandom_range(1, 3), rd, 0, -1);
      n_chk++;
      if (o_acc !== exp_w || s_op !== (exp_w ? op1 : op0)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: granted %0d ops %h, required %0d ops %h",
                           i, o_acc, s_op, exp_w, exp_w ? op1 : op0);
      end
      n_chk++;
      if (rsp_port !== exp_w || s_data !== rd || s_err !== 1'b0 || cross_bad !== 0) begin
        n_fail++; $display("FAIL rr_route[%0d]: port %0d data %h err %b, required port %0d data %h err 0",
                           i, rsp_port, s_data, s_err, exp_w, rd);
      end
      m_last = exp_w;
    end
  endtask

  task automatic test_busy();
    logic [15:0] rd;
    rd = 16'($urandom);
    run_txn(0, 1, 36'h0, {4'h3, 16'h1234, 16'h00FF}, 2, rd, 3, -1);
    n_chk++;
    if (busy_ready_bad !== 0) begin n_fail++; $display("FAIL busy_ready: ready seen while busy, required 0"); end
    n_chk++;
    if (o_acc !== 1 || acc_cyc !== start_cyc + 3) begin
      n_fail++; $display("FAIL busy_accept: grant %0d at +%0d, required 1 at +3", o_acc, acc_cyc - start_cyc);
    end
    n_chk++;
    if (rsp_port !== 1 || s_data !== rd || s_err !== 1'b0) begin
      n_fail++; $display("FAIL busy_response: port %0d data %h err %b, required 1 %h 0", rsp_port, s_data, s_err, rd);
    end
    m_last = 1;
  endtask

  task automatic test_timeout();
    run_txn(1, 0, {4'h1, 16'h7FFF, 16'h8000}, 36'h0, -1, 16'hBEEF, 0, 5);
    n_chk++;
    if (rsp_port !== 0 || rsp_cyc !== iv_cyc + TIMEOUT + 1 || s_data !== 16'h0 || s_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_rsp: port %0d at issue+%0d data %h err %b, required 0 at issue+%0d data 0 err 1",
                         rsp_port, rsp_cyc - iv_cyc, s_data, s_err, TIMEOUT + 1);
    end
    n_chk++;
    if (rsp_cnt !== 1) begin n_fail++; $display("FAIL timeout_stray: %0d responses, required 1", rsp_cnt); end
    m_last = 0;
  endtask

  task automatic test_coincide();
    run_txn(1, 0, {4'h2, 16'h0101, 16'h0202}, 36'h0, TIMEOUT, 16'h5A5A, 0, -1);
    n_chk++;
    if (rsp_cyc !== iv_cyc + TIMEOUT + 1 || s_data !== 16'h5A5A || s_err !== 1'b0) begin
      n_fail++; $display("FAIL coincide_last_cycle: at issue+%0d data %h err %b, required issue+%0d data 5a5a err 0",
                         rsp_cyc - iv_cyc, s_data, s_err, TIMEOUT + 1);
    end
    m_last = 0;
    run_txn(0, 1, 36'h0, {4'h2, 16'h0303, 16'h0404}, TIMEOUT + 1, 16'hA5A5, 0, -1);
    n_chk++;
    if (rsp_port !== 1 || rsp_cyc !== iv_cyc + TIMEOUT + 1 || s_data !== 16'h0 || s_err !== 1'b1 || rsp_cnt !== 1) begin
      n_fail++; $display("FAIL coincide_one_late: port %0d at issue+%0d data %h err %b n %0d, required 1 issue+%0d 0 1 1",
                         rsp_port, rsp_cyc - iv_cyc, s_data, s_err, rsp_cnt, TIMEOUT + 1);
    end
    m_last = 1;
  endtask

  task automatic test_random();
    logic [35:0] op0, op1;
    logic [15:0] rd, exp_d;
    int r, lat, exp_w, exp_c;
    bit v0, v1, exp_e;
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(1, 3); v0 = r[0]; v1 = r[1];
      op0 = {$urandom, $urandom}; op1 = {$urandom, $urandom}; rd = 16'($urandom);
      r = $urandom_range(0, 9);
      lat = (r < 7) ? $urandom_range(1, 4) : ((r < 9) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 1) : -1);
      exp_w = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
      if (lat >= 1 && lat <= TIMEOUT) begin exp_d = rd; exp_e = 0; exp_c = lat + 2; end
      else begin exp_d = 16'h0; exp_e = 1; exp_c = TIMEOUT + 2; end
      run_txn(v0, v1, op0, op1, lat, rd, 0, -1);
      n_chk++;
      if (o_acc !== exp_w || iv_cyc !== acc_cyc + 1 || s_op !== (exp_w ? op1 : op0)) begin
        n_fail++; $display("FAIL rand_issue[%0d]: grant %0d issue T+%0d ops %h, required %0d T+1 %h",
                           i, o_acc, iv_cyc - acc_cyc, s_op, exp_w, exp_w ? op1 : op0);
      end
      n_chk++;
      if (rsp_port !== exp_w || rsp_cyc !== acc_cyc + exp_c || s_data !== exp_d || s_err !== exp_e ||
          cross_bad !== 0 || rsp_cnt !== 1) begin
        n_fail++; $display("FAIL rand_rsp[%0d]: port %0d T+%0d data %h err %b n %0d, required %0d T+%0d %h %b 1",
                           i, rsp_port, rsp_cyc - acc_cyc, s_data, s_err, rsp_cnt, exp_w, exp_c, exp_d, exp_e);
      end
      m_last = exp_w;
    end
  endtask

  task automatic test_reset_mid();
    int n_rsp, n_iv;
    run_txn(1, 0, {4'h4, 16'h0010, 16'h0020}, 36'h0, 1, 16'h0030, 0, -1);
    n_chk++;
    if (o_acc !== 0) begin n_fail++; $display("FAIL rmid_prev_grant: got %0d required 0", o_acc); end
    m_last = 0;
    @(posedge clk); #1;
    bus.req0_valid = 1; {bus.req0_inst, bus.req0_a, bus.req0_b} = {4'h5, 16'h1111, 16'h2222};
    @(negedge clk);
    n_chk++;
    if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_accept: ready0 %b required 1", bus.req0_ready); end
    @(posedge clk); #1;
    bus.req1_valid = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready, bus.alu_in_valid, bus.alu_inst, bus.alu_data_a, bus.alu_data_b,
         bus.rsp0_valid, bus.rsp0_data, bus.rsp0_err, bus.rsp1_valid, bus.rsp1_data, bus.rsp1_err} !== '0) begin
      n_fail++; $display("FAIL rmid_outputs: iv=%b inst=%h a=%h b=%h r0=%b r1=%b required all 0",
                         bus.alu_in_valid, bus.alu_inst, bus.alu_data_a, bus.alu_data_b, bus.req0_ready, bus.req1_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = 1;
    #1;
    n_chk++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_first_winner: ready0 %b ready1 %b required 1 0", bus.req0_ready, bus.req1_ready);
    end
    #1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    n_rsp = 0; n_iv = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      bus.alu_out_valid = (k == 3);
      bus.alu_data = 16'h7777;
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid) n_rsp++;
      if (bus.alu_in_valid) n_iv++;
    end
    bus.alu_out_valid = 0;
    n_chk++;
    if (n_rsp !== 0 || n_iv !== 0) begin
      n_fail++; $display("FAIL rmid_abandoned: %0d responses %0d issues, required 0 0", n_rsp, n_iv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_busy();
    test_timeout();
    test_coincide();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
